// File: rtl/mfrsd_spi.sv
// Byte-wide SPI master, mode 0, MSB first.
// One strobe starts a full 8-bit exchange on spi_sclk/mosi/miso.
module mfrsd_spi #(
  parameter int HALF_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_to_sd,
  input  logic       sd_tx,
  input  logic       sd_rx,
  output logic [7:0] d_from_sd,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] HLAST = 8'(HALF_DIV - 1);

  state_t     state;
  logic [7:0] hcnt;
  logic [2:0] bcnt;
  logic [7:0] sr;
  logic       miso_q;
  logic       strobe;

  assign strobe = sd_tx | sd_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hcnt      <= 8'd0;
      bcnt      <= 3'd0;
      sr        <= 8'hFF;
      miso_q    <= 1'b0;
      d_from_sd <= 8'hFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b1;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strobe) begin
            sr       <= sd_tx ? d_to_sd : 8'hFF;
            spi_mosi <= sd_tx ? d_to_sd[7] : 1'b1;
            busy     <= 1'b1;
            hcnt     <= 8'd0;
            bcnt     <= 3'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          overrun <= strobe;
          if (hcnt == HLAST) begin
            hcnt     <= 8'd0;
            spi_sclk <= ~spi_sclk;
            // Sampled bit is held aside so tx bit 0 survives until sent.
            if (!spi_sclk) begin
              miso_q <= spi_miso;
            end else begin
              sr   <= {sr[6:0], miso_q};
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                d_from_sd <= {sr[6:0], miso_q};
                done      <= 1'b1;
                busy      <= 1'b0;
                spi_mosi  <= 1'b1;
                state     <= IDLE;
              end else begin
                spi_mosi <= sr[6];
              end
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfrsd_spi.sv
// Bench for mfrsd_spi: HALF_DIV=2 and HALF_DIV=1 instances
// driven with the same strobes; vector table plus corner sequences.
module tb_mfrsd_spi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d_to_sd = 8'h00;
  logic       sd_tx = 1'b0;
  logic       sd_rx = 1'b0;

  logic [7:0] dout0, dout1;
  logic       busy0, busy1, done0, done1, ovr0, ovr1;
  logic       sclk0, sclk1, mosi0, mosi1, miso0, miso1;

  logic       loop = 1'b1;
  logic [7:0] slave = 8'h00;
  logic [2:0] sidx = 3'd0;
  logic [7:0] mcap = 8'h00;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mfrsd_spi #(.HALF_DIV(2)) u0 (
    .clk(clk), .reset(reset), .d_to_sd(d_to_sd),
    .sd_tx(sd_tx), .sd_rx(sd_rx), .d_from_sd(dout0),
    .busy(busy0), .done(done0), .overrun(ovr0),
    .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  mfrsd_spi #(.HALF_DIV(1)) u1 (
    .clk(clk), .reset(reset), .d_to_sd(d_to_sd),
    .sd_tx(sd_tx), .sd_rx(sd_rx), .d_from_sd(dout1),
    .busy(busy1), .done(done1), .overrun(ovr1),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Slave presents MSB first, advancing after each SCLK rise.
  always @(posedge sclk0 or negedge busy0)
    if (!busy0) sidx <= 3'd0;
    else        sidx <= sidx + 3'd1;

  always @(posedge sclk0) mcap <= {mcap[6:0], mosi0};

  assign miso0 = loop ? mosi0 : slave[3'd7 - sidx];
  assign miso1 = mosi1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start(input bit tx, input bit rx, input logic [7:0] d);
    @(negedge clk);
    sd_tx = tx;
    sd_rx = rx;
    d_to_sd = d;
  endtask

  task automatic measure(
    input  int         inj,
    input  logic [7:0] injd,
    input  int         hold,
    input  bit         b2b,
    input  logic [7:0] b2bd,
    output int         l0,
    output int         l1,
    output int         bc,
    output int         oc
  );
    logic htx, hrx;
    htx = sd_tx;
    hrx = sd_rx;
    l0 = 0; l1 = 0; bc = 0; oc = 0;
    for (int c = 1; c <= 200 && l0 == 0; c++) begin
      @(negedge clk);
      sd_tx = (c < hold) ? htx : 1'b0;
      sd_rx = (c < hold) ? hrx : 1'b0;
      if (c == inj) begin
        sd_tx = 1'b1;
        d_to_sd = injd;
      end
      if (busy0) bc++;
      if (ovr0) oc++;
      if (done1 && l1 == 0) l1 = c;
      if (done0 && l0 == 0) begin
        l0 = c;
        if (b2b) begin
          sd_tx = 1'b1;
          d_to_sd = b2bd;
        end
      end
    end
  endtask

  typedef struct {
    bit         tx;
    bit         rx;
    logic [7:0] d;
    bit         lp;
    logic [7:0] slv;
    logic [7:0] exp_d0;
    logic [7:0] exp_m;
    logic [7:0] exp_d1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int l0, l1, bc, oc, seen;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h3C, 8'h3C, 8'hFF, 8'hFF};
    vecs[2] = '{1'b1, 1'b1, 8'h40, 1'b1, 8'h00, 8'h40, 8'h40, 8'h40};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hC3, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h81, 1'b0, 8'h7E, 8'h7E, 8'h81, 8'h81};

    repeat (3) @(negedge clk);
    chk("rst_sclk", int'(sclk0), 0);
    chk("rst_mosi", int'(mosi0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_dout", int'(dout0), 'hFF);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_done", int'(done0), 0);
    chk("idle_ovr", int'(ovr0), 0);

    for (int i = 0; i < 5; i++) begin
      loop = vecs[i].lp;
      slave = vecs[i].slv;
      start(vecs[i].tx, vecs[i].rx, vecs[i].d);
      measure(0, 8'h00, 0, 1'b0, 8'h00, l0, l1, bc, oc);
      chk($sformatf("v%0d_lat0", i), l0, 33);
      chk($sformatf("v%0d_lat1", i), l1, 17);
      chk($sformatf("v%0d_busy", i), bc, 32);
      chk($sformatf("v%0d_ovr", i), oc, 0);
      chk($sformatf("v%0d_dout0", i), int'(dout0), int'(vecs[i].exp_d0));
      chk($sformatf("v%0d_mosi", i), int'(mcap), int'(vecs[i].exp_m));
      chk($sformatf("v%0d_dout1", i), int'(dout1), int'(vecs[i].exp_d1));
      chk($sformatf("v%0d_idle", i), int'({mosi0, sclk0}), 2);
      repeat (2) @(negedge clk);
    end

    // Strobe mid-transfer, then a back-to-back strobe in the done cycle.
    loop = 1'b1;
    start(1'b1, 1'b0, 8'hA5);
    measure(10, 8'h00, 0, 1'b1, 8'h5A, l0, l1, bc, oc);
    chk("ovr_lat", l0, 33);
    chk("ovr_cnt", oc, 1);
    chk("ovr_dout", int'(dout0), 'hA5);
    measure(0, 8'h00, 0, 1'b0, 8'h00, l0, l1, bc, oc);
    chk("b2b_lat", l0, 33);
    chk("b2b_dout", int'(dout0), 'h5A);
    chk("b2b_ovr", oc, 0);
    repeat (2) @(negedge clk);

    // Strobe held three cycles: one accept, then two overruns.
    start(1'b1, 1'b0, 8'h96);
    measure(0, 8'h00, 3, 1'b0, 8'h00, l0, l1, bc, oc);
    chk("hold_lat", l0, 33);
    chk("hold_ovr", oc, 2);
    chk("hold_dout", int'(dout0), 'h96);
    repeat (2) @(negedge clk);

    // Reset mid-transfer.
    start(1'b1, 1'b0, 8'hA5);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      sd_tx = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("ar_sclk", int'(sclk0), 0);
    chk("ar_busy", int'(busy0), 0);
    chk("ar_dout", int'(dout0), 'hFF);
    chk("ar_mosi", int'(mosi0), 1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) seen++;
    end
    chk("ar_nodone", seen, 0);
    reset = 1'b0;
    sd_tx = 1'b1;
    d_to_sd = 8'h01;
    measure(0, 8'h00, 0, 1'b0, 8'h00, l0, l1, bc, oc);
    chk("ar_lat", l0, 33);
    chk("ar_dout", int'(dout0), 'h01);
    chk("ar_mosi_bits", int'(mcap), 'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
